// File: rtl/fsmc_mux_master.sv
// Initiator for the multiplexed NE/NADV/NOE/NWE address/data bus: one single-beat
// read or write per request, with parameterised phase lengths.
module fsmc_mux_master #(
  parameter int unsigned ADDSET  = 2,
  parameter int unsigned ADDHLD  = 1,
  parameter int unsigned DATAST  = 3,
  parameter int unsigned BUSTURN = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        WR,
  input  logic [18:0] ADDR,
  input  logic [15:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] RDATA,
  output logic        NE,
  output logic        NADV,
  output logic        NOE,
  output logic        NWE,
  output logic [2:0]  A_HI,
  output logic [15:0] AD_OUT,
  output logic        AD_OE,
  input  logic [15:0] AD_IN
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AHLD, S_DATA, S_TURN} state_t;

  // A zero-length phase is stretched to one cycle.
  function automatic logic [3:0] phase_ld(input int unsigned p);
    return (p == 0) ? 4'd0 : 4'(p - 1);
  endfunction

  localparam logic [3:0] ADDSET_LD  = phase_ld(ADDSET);
  localparam logic [3:0] ADDHLD_LD  = phase_ld(ADDHLD);
  localparam logic [3:0] DATAST_LD  = phase_ld(DATAST);
  localparam logic [3:0] BUSTURN_LD = phase_ld(BUSTURN);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ne_q, ne_d;
  logic        nadv_q, nadv_d;
  logic        noe_q, noe_d;
  logic        nwe_q, nwe_d;
  logic [2:0]  a_hi_q, a_hi_d;
  logic [15:0] ad_out_q, ad_out_d;
  logic        ad_oe_q, ad_oe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          wr_d    = WR;
          addr_d  = ADDR;
          wdata_d = WDATA;
          state_d = S_ADDR;
          cnt_d   = ADDSET_LD;
        end
      end
      S_ADDR: begin
        if (cnt_q == 4'd0) begin
          state_d = S_AHLD;
          cnt_d   = ADDHLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_AHLD: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
          cnt_d   = DATAST_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 4'd0) begin
          state_d = S_TURN;
          cnt_d   = BUSTURN_LD;
          if (!wr_q) rdata_d = AD_IN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    // Pad outputs are decoded from the next state so they are registered
    // and line up with the state they belong to.
    busy_d   = (state_d != S_IDLE);
    ne_d     = 1'b1;
    nadv_d   = 1'b1;
    noe_d    = 1'b1;
    nwe_d    = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = ad_out_q;
    a_hi_d   = a_hi_q;

    case (state_d)
      S_ADDR: begin
        ne_d     = 1'b0;
        nadv_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d[15:0];
        a_hi_d   = addr_d[18:16];
      end
      S_AHLD: begin
        ne_d     = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_d[15:0];
        a_hi_d   = addr_d[18:16];
      end
      S_DATA: begin
        ne_d = 1'b0;
        if (wr_d) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_d;
          nwe_d    = 1'b0;
        end else begin
          noe_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      addr_q   <= 19'd0;
      wdata_q  <= 16'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 16'd0;
      ne_q     <= 1'b1;
      nadv_q   <= 1'b1;
      noe_q    <= 1'b1;
      nwe_q    <= 1'b1;
      a_hi_q   <= 3'd0;
      ad_out_q <= 16'd0;
      ad_oe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      ne_q     <= ne_d;
      nadv_q   <= nadv_d;
      noe_q    <= noe_d;
      nwe_q    <= nwe_d;
      a_hi_q   <= a_hi_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RDATA  = rdata_q;
  assign NE     = ne_q;
  assign NADV   = nadv_q;
  assign NOE    = noe_q;
  assign NWE    = nwe_q;
  assign A_HI   = a_hi_q;
  assign AD_OUT = ad_out_q;
  assign AD_OE  = ad_oe_q;

endmodule

// File: tb/tb_fsmc_mux_master.sv
// Bench for fsmc_mux_master: bus monitor plus scoreboard at default timing, and a
// second instance with stretched phases.
module tb_fsmc_mux_master;

  localparam int ADDSET  = 2;
  localparam int ADDHLD  = 1;
  localparam int DATAST  = 3;
  localparam int BUSTURN = 1;
  localparam int LATENCY = ADDSET + ADDHLD + DATAST + BUSTURN;
  localparam int TXN_W   = 52;

  typedef struct packed {
    logic        wr;
    logic [18:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } txn_t;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        req, wr;
  logic [18:0] addr;
  logic [15:0] wdata;
  logic        busy, done, ne, nadv, noe, nwe, ad_oe;
  logic [15:0] rdata, ad_out, ad_in;
  logic [2:0]  a_hi;

  logic        req2;
  logic        busy2, done2, ne2, nadv2, noe2, nwe2, ad_oe2;
  logic [15:0] rdata2, ad_out2, ad_in2;
  logic [2:0]  a_hi2;

  int tests;
  int fails;
  logic [TXN_W-1:0] exp_q[$];
  logic [15:0] last_rd;
  int done_n;

  // slave read model: data returned is a fixed function of the latched address
  logic [18:0] cap_addr;
  function automatic logic [15:0] rd_model(input logic [18:0] a);
    return a[15:0] ^ 16'h3C5B;
  endfunction

  assign ad_in  = !noe  ? rd_model(cap_addr) : 16'hFFFF;
  assign ad_in2 = !noe2 ? 16'h1234 : 16'hFFFF;

  fsmc_mux_master dut (
    .CLK(clk), .RST(rst), .REQ(req), .WR(wr), .ADDR(addr), .WDATA(wdata),
    .BUSY(busy), .DONE(done), .RDATA(rdata), .NE(ne), .NADV(nadv), .NOE(noe),
    .NWE(nwe), .A_HI(a_hi), .AD_OUT(ad_out), .AD_OE(ad_oe), .AD_IN(ad_in)
  );

  fsmc_mux_master #(.ADDSET(0), .ADDHLD(1), .DATAST(15), .BUSTURN(1)) dut2 (
    .CLK(clk), .RST(rst), .REQ(req2), .WR(wr), .ADDR(addr), .WDATA(wdata),
    .BUSY(busy2), .DONE(done2), .RDATA(rdata2), .NE(ne2), .NADV(nadv2), .NOE(noe2),
    .NWE(nwe2), .A_HI(a_hi2), .AD_OUT(ad_out2), .AD_OE(ad_oe2), .AD_IN(ad_in2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // monitor + scoreboard
  int nadv_n, ahld_n, data_n, turn_n, busy_n;
  logic addr_bad, wd_bad;
  logic [15:0] cap_wd;

  always @(negedge clk) begin
    txn_t e;
    if (rst) begin
      nadv_n = 0; ahld_n = 0; data_n = 0; turn_n = 0; busy_n = 0;
      addr_bad = 1'b0; wd_bad = 1'b0;
    end else begin
      if (busy) busy_n++;
      if (!nadv) begin
        if (nadv_n == 0) cap_addr = {a_hi, ad_out};
        else if ({a_hi, ad_out} !== cap_addr) addr_bad = 1'b1;
        if (!ad_oe || ne) addr_bad = 1'b1;
        nadv_n++;
      end else if (busy && !ne && noe && nwe) begin
        if ({a_hi, ad_out} !== cap_addr || !ad_oe) addr_bad = 1'b1;
        ahld_n++;
      end
      if (!nwe) begin
        if (data_n == 0) cap_wd = ad_out;
        else if (ad_out !== cap_wd) wd_bad = 1'b1;
        if (!ad_oe || ne) wd_bad = 1'b1;
        data_n++;
      end
      if (!noe) begin
        chk("ad_oe_while_noe", ad_oe, 1'b0);
        chk("nwe_while_noe", nwe, 1'b1);
        data_n++;
      end
      if (busy && ne) turn_n++;
      if (done) begin
        done_n++;
        chk("busy_at_done", busy, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1'b1, 1'b0);
        end else begin
          e = txn_t'(exp_q.pop_front());
          chk("addr", cap_addr, e.addr);
          chk("addr_stable", addr_bad, 1'b0);
          chk("nadv_cycles", nadv_n, ADDSET);
          chk("ahld_cycles", ahld_n, ADDHLD);
          chk("data_cycles", data_n, DATAST);
          chk("turn_cycles", turn_n, BUSTURN);
          chk("latency", busy_n, LATENCY);
          chk("rdata", rdata, e.rdata);
          if (e.wr) begin
            chk("wdata", cap_wd, e.wdata);
            chk("wdata_stable", wd_bad, 1'b0);
          end
        end
        nadv_n = 0; ahld_n = 0; data_n = 0; turn_n = 0; busy_n = 0;
        addr_bad = 1'b0; wd_bad = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic push_txn(input logic w, input logic [18:0] a, input logic [15:0] d);
    txn_t e;
    e.wr = w; e.addr = a; e.wdata = d;
    if (!w) last_rd = rd_model(a);
    e.rdata = last_rd;
    exp_q.push_back(TXN_W'(e));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic do_txn(input logic w, input logic [18:0] a, input logic [15:0] d);
    wait_idle();
    wr = w; addr = a; wdata = d;
    push_txn(w, a, d);
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    wr = 1'($urandom); addr = 19'($urandom); wdata = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int pushes, d0, b, na, no;
    logic seen, any_done;
    tests = 0; fails = 0; done_n = 0; last_rd = 16'h0; cap_addr = 19'h0;
    rst = 1'b1; req = 1'b0; req2 = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset / idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_outs", {ne, nadv, noe, nwe, ad_oe, busy, done}, 7'b1111000);
    end
    chk("reset_rdata", rdata, 16'h0);
    chk("reset_ad_a", {a_hi, ad_out}, 19'h0);

    // directed write then read, then a write that must not disturb RDATA
    do_txn(1'b1, 19'h50001, 16'hA5C3);
    drain();
    do_txn(1'b0, 19'h50001, 16'h0000);
    drain();
    chk("read_value", rdata, 16'h3C5A);
    do_txn(1'b1, 19'h12345, 16'h0F0F);
    drain();
    chk("rdata_held", rdata, 16'h3C5A);

    // REQ held high: transfers accepted on the DONE cycle
    pushes = 0;
    d0 = done_n;
    wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clk);
      if (!busy) begin
        wr = (pushes % 2 == 0) ? 1'b0 : 1'b1;
        addr = 19'($urandom); wdata = 16'($urandom);
        push_txn(wr, addr, wdata);
        pushes++;
      end else begin
        addr = 19'($urandom); wdata = 16'($urandom);
      end
      req = 1'b1;
    end
    @(negedge clk);
    req = 1'b0;
    drain();
    chk("chain_count", pushes, 3);
    chk("chain_dones", done_n - d0, pushes);

    // reset during the second DATA cycle of a write
    wait_idle();
    wr = 1'b1; addr = 19'h2AAAA; wdata = 16'h5555;
    push_txn(1'b1, 19'h2AAAA, 16'h5555);
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_data_nwe", {nwe, ad_oe}, 2'b01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    last_rd = 16'h0;
    chk("rst_release", {ne, nadv, noe, nwe, ad_oe, busy, done}, 7'b1111000);
    chk("rst_rdata", rdata, 16'h0);
    rst = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    chk("no_done_after_rst", any_done, 1'b0);
    do_txn(1'b0, 19'h7ABCD, 16'h0000);
    drain();

    // random mix
    for (int i = 0; i < 6; i++) begin
      do_txn(1'($urandom_range(0, 1)), 19'($urandom), 16'($urandom_range(0, 16'hFFFF)));
    end
    drain();

    // stretched phases on the second instance
    @(negedge clk);
    wr = 1'b0; addr = 19'h40010;
    req2 = 1'b1;
    @(posedge clk);
    #1 req2 = 1'b0;
    b = 0; na = 0; no = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy2) b++;
      if (!nadv2) na++;
      if (!noe2) no++;
      if (done2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("p2_done_seen", seen, 1'b1);
    chk("p2_latency", b, 18);
    chk("p2_nadv_cycles", na, 1);
    chk("p2_noe_cycles", no, 15);
    chk("p2_rdata", rdata2, 16'h1234);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
